// File: rtl/pc_stall_ctrl.sv
// Program-counter stall/flush controller for a 5-stage RISC-V pipeline.
// Resolves load-use, branch and data-cache-miss hazards; tracks lost fetch cycles.
module pc_stall_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        load_use_i,
  input  logic        branch_taken_i,
  input  logic        dcache_miss_i,
  input  logic        mem_ack_i,
  output logic        PC_write_o,
  output logic        IF_ID_write_o,
  output logic        IF_ID_flush_o,
  output logic        ID_EX_bubble_o,
  output logic        pipe_stall_o,
  output logic        mem_req_o,
  output logic        err_o,
  output logic [1:0]  state_o,
  output logic [15:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  wait_q;
  logic [7:0]  wait_d;
  logic [7:0]  wait_inc;
  logic [15:0] cnt_q;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        stall;
  logic        lost_fetch;

  assign wait_inc = wait_q + 8'd1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    stall       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_RUN;
      end
      S_RUN: begin
        if (dcache_miss_i) begin
          stall   = 1'b1;
          wait_d  = 8'd0;
          state_d = S_WAIT;
        end else begin
          // load-use beats a taken branch; branch is re-presented next cycle
          if (load_use_i) begin
            idex_bubble = 1'b1;
          end else if (branch_taken_i) begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            ifid_flush = 1'b1;
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
          end
          state_d = start_i ? S_RUN : S_IDLE;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        // an ack on the timeout cycle still completes the transaction
        if (mem_ack_i) begin
          state_d = start_i ? S_RUN : S_IDLE;
        end else if (wait_inc == TMO) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_ERR: begin
        stall = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign lost_fetch = ((state_q == S_RUN) || (state_q == S_WAIT))
                    && !pc_write;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= 16'd0;
    end else if (lost_fetch && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign PC_write_o     = pc_write;
  assign IF_ID_write_o  = ifid_write;
  assign IF_ID_flush_o  = ifid_flush;
  assign ID_EX_bubble_o = idex_bubble;
  assign pipe_stall_o   = stall;
  assign mem_req_o      = (state_q == S_WAIT);
  assign err_o          = (state_q == S_ERR);
  assign state_o        = state_q;
  assign stall_cnt_o    = cnt_q;

endmodule

// File: tb/tb_pc_stall_ctrl.sv
// Directed scoreboard bench for pc_stall_ctrl.
// One instance at default TIMEOUT, one at TIMEOUT=4 for the error path.
module tb_pc_stall_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst4, start, lu, br, miss, ack;

  logic        m_pc, m_ifw, m_fl, m_bub, m_stl, m_req, m_err;
  logic [1:0]  m_st;
  logic [15:0] m_cnt;
  logic        t_pc, t_ifw, t_fl, t_bub, t_stl, t_req, t_err;
  logic [1:0]  t_st;
  logic [15:0] t_cnt;

  pc_stall_ctrl dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .load_use_i(lu), .branch_taken_i(br),
    .dcache_miss_i(miss), .mem_ack_i(ack),
    .PC_write_o(m_pc), .IF_ID_write_o(m_ifw),
    .IF_ID_flush_o(m_fl), .ID_EX_bubble_o(m_bub),
    .pipe_stall_o(m_stl), .mem_req_o(m_req),
    .err_o(m_err), .state_o(m_st), .stall_cnt_o(m_cnt)
  );

  pc_stall_ctrl #(.TIMEOUT(4)) dut4 (
    .clk_i(clk), .rst_i(rst4), .start_i(start),
    .load_use_i(lu), .branch_taken_i(br),
    .dcache_miss_i(miss), .mem_ack_i(ack),
    .PC_write_o(t_pc), .IF_ID_write_o(t_ifw),
    .IF_ID_flush_o(t_fl), .ID_EX_bubble_o(t_bub),
    .pipe_stall_o(t_stl), .mem_req_o(t_req),
    .err_o(t_err), .state_o(t_st), .stall_cnt_o(t_cnt)
  );

  // flag order: pc, ifid_write, flush, bubble, stall, req, err
  localparam logic [6:0] F0     = 7'b0000000;
  localparam logic [6:0] F_RUN  = 7'b1100000;
  localparam logic [6:0] F_BR   = 7'b1110000;
  localparam logic [6:0] F_LU   = 7'b0001000;
  localparam logic [6:0] F_MISS = 7'b0000100;
  localparam logic [6:0] F_WAIT = 7'b0000110;
  localparam logic [6:0] F_ERR  = 7'b0000101;

  typedef struct {
    string       tag;
    logic [24:0] v;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] cnt_m = 16'd0;
  logic [15:0] cnt_t = 16'd0;

  wire [24:0] obs_m = {m_st, m_pc, m_ifw, m_fl, m_bub,
                       m_stl, m_req, m_err, m_cnt};
  wire [24:0] obs_t = {t_st, t_pc, t_ifw, t_fl, t_bub,
                       t_stl, t_req, t_err, t_cnt};

  function automatic logic [15:0] sat_inc(logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  task automatic check_now(string tag, int sel,
                           logic [1:0] est, logic [6:0] ef);
    exp_t        e;
    logic [24:0] obs;
    e.tag = tag;
    e.v   = {est, ef, (sel == 1) ? cnt_t : cnt_m};
    sbq.push_back(e);
    obs = (sel == 1) ? obs_t : obs_m;
    e = sbq.pop_front();
    checks++;
    assert (obs === e.v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
    end
  endtask

  task automatic step(string tag, int sel,
                      bit s, bit l, bit b, bit m, bit a,
                      logic [1:0] est, logic [6:0] ef);
    start = s; lu = l; br = b; miss = m; ack = a;
    #2;
    check_now(tag, sel, est, ef);
    if ((est == 2'd1 || est == 2'd2) && !ef[6]) begin
      if (sel == 1) cnt_t = sat_inc(cnt_t);
      else          cnt_m = sat_inc(cnt_m);
    end
    @(negedge clk);
  endtask

  task automatic reset_both();
    rst = 1'b0; rst4 = 1'b0;
    start = 1'b0; lu = 1'b0; br = 1'b0; miss = 1'b0; ack = 1'b0;
    #1;
    cnt_m = 16'd0; cnt_t = 16'd0;
    check_now("reset_main", 0, 2'd0, F0);
    check_now("reset_t4", 1, 2'd0, F0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; rst4 = 1'b0;
    start = 1'b0; lu = 1'b0; br = 1'b0; miss = 1'b0; ack = 1'b0;
    reset_both();
    rst = 1'b1;

    step("idle_start", 0, 1,0,0,0,0, 2'd0, F0);
    step("run",        0, 1,0,0,0,0, 2'd1, F_RUN);
    step("load_use",   0, 1,1,0,0,0, 2'd1, F_LU);
    step("after_lu",   0, 1,0,0,0,0, 2'd1, F_RUN);
    step("lu_and_br",  0, 1,1,1,0,0, 2'd1, F_LU);
    step("br_alone",   0, 1,0,1,0,0, 2'd1, F_BR);

    reset_both();
    rst = 1'b1;
    step("idle2",      0, 1,0,0,0,0, 2'd0, F0);
    step("miss",       0, 1,0,0,1,0, 2'd1, F_MISS);
    step("wait1",      0, 0,0,0,0,0, 2'd2, F_WAIT);
    step("wait2_ign",  0, 0,1,1,0,0, 2'd2, F_WAIT);
    step("wait3",      0, 0,0,0,1,0, 2'd2, F_WAIT);
    step("wait4",      0, 0,0,0,0,0, 2'd2, F_WAIT);
    step("wait5_ack",  0, 0,0,0,0,1, 2'd2, F_WAIT);
    step("idle_cnt6",  0, 0,0,0,0,0, 2'd0, F0);
    step("ack_idle",   0, 0,0,0,0,1, 2'd0, F0);
    step("idle3",      0, 1,0,0,0,0, 2'd0, F0);
    step("ack_run",    0, 1,0,0,0,1, 2'd1, F_RUN);
    step("miss2",      0, 1,0,0,1,0, 2'd1, F_MISS);
    step("wait_a",     0, 1,0,0,0,0, 2'd2, F_WAIT);

    // async reset in the middle of a memory wait
    start = 1'b1; lu = 1'b0; br = 1'b0; miss = 1'b0; ack = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    cnt_m = 16'd0;
    check_now("rst_mid_wait", 0, 2'd0, F0);
    @(negedge clk);
    rst = 1'b1;
    step("post_rst",   0, 1,0,0,0,0, 2'd0, F0);
    step("run4",       0, 1,0,0,0,0, 2'd1, F_RUN);

    start = 1'b1; lu = 1'b1;
    for (int i = 0; i < 65534; i++) begin
      @(negedge clk);
      cnt_m = sat_inc(cnt_m);
    end
    step("sat_fffe",   0, 1,1,0,0,0, 2'd1, F_LU);
    step("sat_ffff",   0, 1,1,0,0,0, 2'd1, F_LU);
    step("sat_hold",   0, 1,1,0,0,0, 2'd1, F_LU);
    step("sat_run",    0, 1,0,0,0,0, 2'd1, F_RUN);

    reset_both();
    rst = 1'b1; rst4 = 1'b1;
    step("t4_idle",    1, 1,0,0,0,0, 2'd0, F0);
    step("t4_run",     1, 1,0,0,0,0, 2'd1, F_RUN);
    step("t4_miss",    1, 1,0,0,1,0, 2'd1, F_MISS);
    for (int i = 0; i < 4; i++) begin
      step("t4_wait",  1, 1,0,0,0,0, 2'd2, F_WAIT);
    end
    step("t4_err_ack", 1, 1,0,0,0,1, 2'd3, F_ERR);
    step("t4_err",     1, 1,0,0,0,0, 2'd3, F_ERR);
    step("t4_err_in",  1, 1,1,1,1,0, 2'd3, F_ERR);

    reset_both();
    rst = 1'b1; rst4 = 1'b1;
    step("t4_idle2",   1, 1,0,0,0,0, 2'd0, F0);
    step("t4_run2",    1, 1,0,0,0,0, 2'd1, F_RUN);
    step("t4_miss2",   1, 1,0,0,1,0, 2'd1, F_MISS);
    for (int i = 0; i < 3; i++) begin
      step("t4_wait2", 1, 1,0,0,0,0, 2'd2, F_WAIT);
    end
    step("t4_ack_lim", 1, 1,0,0,0,1, 2'd2, F_WAIT);
    step("t4_back",    1, 1,0,0,0,0, 2'd1, F_RUN);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
